// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers
// One result bit per CALC cycle; signs are stripped in LOAD and restored in FIX.
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             hilo_rd_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CALC = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               sign_a, sign_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;

  // Multiply: a_q is the multiplicand, b_q shifts right to expose one multiplier bit.
  // Divide: a_q shifts left feeding dividend bits, b_q holds the divisor.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    div_ge   = (rem_sh >= {1'b0, b_q});
    prod_fix = neg_quo_q ? -acc_q : acc_q;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    sign_a    = op_q[0] & a_q[WIDTH-1];
    sign_b    = op_q[0] & b_q[WIDTH-1];

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d    = op_i;
          a_d     = a_i;
          b_d     = b_i;
          state_d = S_LOAD;
        end else begin
          if (hi_we_i) hi_d = wdata_i;
          if (lo_we_i) lo_d = wdata_i;
        end
      end
      S_LOAD: begin
        a_d       = sign_a ? -a_q : a_q;
        b_d       = sign_b ? -b_q : b_q;
        neg_quo_d = sign_a ^ sign_b;
        neg_rem_d = sign_a;
        acc_d     = '0;
        cnt_d     = '0;
        state_d   = S_CALC;
      end
      S_CALC: begin
        if (op_q[1]) begin
          // Restoring step: upper half is the partial remainder, lower half collects quotient bits.
          acc_d = {(div_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], div_ge};
          a_d   = a_q << 1;
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          b_d   = b_q >> 1;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (op_q[1]) begin
          lo_d = neg_quo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy_o  = (state_q != S_IDLE);
  assign stall_o = busy_o & (start_i | hilo_rd_i | hi_we_i | lo_we_i);
  assign done_o  = done_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - scoreboard bench for mdu_seq
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        hilo_rd, hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  mdu_seq #(.WIDTH(32)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .hilo_rd_i(hilo_rd), .hi_we_i(hi_we), .lo_we_i(lo_we), .wdata_i(wdata),
    .busy_o(busy), .stall_o(stall), .done_o(done), .hi_o(hi), .lo_o(lo)
  );

  always #5 clk = ~clk;

  // Reference {hi, lo} computed with wide signed arithmetic.
  function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] p;
    sa = {{32{ma[31]}}, ma};
    sb = {{32{mb[31]}}, mb};
    p = '0;
    case (mop)
      2'd0: p = {32'd0, ma} * {32'd0, mb};
      2'd1: p = sa * sb;
      2'd2: p = (mb == 0) ? {ma, 32'hFFFF_FFFF} : {ma % mb, ma / mb};
      default: begin
        if (mb == 0) p = {ma, (ma[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  // Called at a negedge; returns at the negedge just after the sampling edge.
  task automatic issue(input logic [1:0] iop, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [63:0] expv, input bit push);
    op = iop; a = ia; b = ib; start = 1'b1;
    if (push) exp_q.push_back(expv);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_result(output bit got, output int nbusy, output bit changed);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo;
    got = 0; nbusy = 0; changed = 0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin got = 1; break; end
      if (busy) nbusy++;
      if (hi !== h0 || lo !== l0) changed = 1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({hi, lo, busy, done, stall} !== 67'd0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d hi=%h lo=%h busy=%b done=%b stall=%b expected all 0", i, hi, lo, busy, done, stall);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mul;
    logic [1:0]  t_op[2] = '{2'd0, 2'd1};
    logic [63:0] t_ex[2] = '{64'h0000_0001_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE};
    bit got, chg; int n; logic [63:0] e;
    for (int k = 0; k < 2; k++) begin
      issue(t_op[k], 32'hFFFF_FFFF, 32'd2, t_ex[k], 1);
      wait_result(got, n, chg);
      checks++;
      if (!got) begin failures++; $display("FAIL mul_timeout k=%0d no done within bound", k); end
      checks++;
      if (n !== 34) begin failures++; $display("FAIL mul_busy_len k=%0d got=%0d expected=34", k, n); end
      checks++;
      if (chg) begin failures++; $display("FAIL mul_early_update k=%0d hi/lo changed before done", k); end
      e = exp_q.pop_front();
      checks++;
      if ({hi, lo} !== e) begin failures++; $display("FAIL mul_result k=%0d got=%h expected=%h", k, {hi, lo}, e); end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mul_done_pulse k=%0d done=%b busy=%b expected 0 0", k, done, busy); end
    end
  endtask

  task automatic test_div;
    logic [1:0]  t_op[4] = '{2'd3, 2'd2, 2'd2, 2'd3};
    logic [31:0] t_a[4]  = '{32'hFFFF_FFF9, 32'd100, 32'd5, 32'h8000_0000};
    logic [31:0] t_b[4]  = '{32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
    logic [63:0] t_ex[4] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0002_0000_000E,
                             64'h0000_0005_FFFF_FFFF, 64'h0000_0000_8000_0000};
    bit got, chg; int n; logic [63:0] e;
    for (int k = 0; k < 4; k++) begin
      issue(t_op[k], t_a[k], t_b[k], t_ex[k], 1);
      wait_result(got, n, chg);
      e = exp_q.pop_front();
      checks++;
      if (!got) begin failures++; $display("FAIL div_timeout k=%0d no done within bound", k); end
      checks++;
      if ({hi, lo} !== e) begin failures++; $display("FAIL div_result k=%0d got=%h expected=%h", k, {hi, lo}, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_mthi_mtlo;
    logic [31:0] l0;
    bit got, chg; int n; logic [63:0] e;
    l0 = lo;
    hilo_rd = 1'b1; hi_we = 1'b1; wdata = 32'h0000_1234;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL idle_stall got=%b expected=0", stall); end
    @(negedge clk);
    hilo_rd = 1'b0; hi_we = 1'b0;
    checks++;
    if (hi !== 32'h0000_1234 || lo !== l0) begin failures++; $display("FAIL mthi hi=%h lo=%h expected hi=00001234 lo=%h", hi, lo, l0); end
    lo_we = 1'b1; wdata = 32'hCAFE_0001;
    @(negedge clk);
    lo_we = 1'b0;
    checks++;
    if (lo !== 32'hCAFE_0001 || hi !== 32'h0000_1234) begin failures++; $display("FAIL mtlo hi=%h lo=%h expected 00001234 cafe0001", hi, lo); end
    // start and a write together: the write must be dropped
    lo_we = 1'b1; wdata = 32'h5555_AAAA;
    issue(2'd2, 32'd200, 32'd9, model(2'd2, 32'd200, 32'd9), 1);
    lo_we = 1'b0;
    checks++;
    if (lo !== 32'hCAFE_0001 || busy !== 1'b1) begin failures++; $display("FAIL start_wins lo=%h busy=%b expected cafe0001 1", lo, busy); end
    wait_result(got, n, chg);
    e = exp_q.pop_front();
    checks++;
    if (!got || {hi, lo} !== e) begin failures++; $display("FAIL start_wins_result got=%b val=%h expected=%h", got, {hi, lo}, e); end
    @(negedge clk);
  endtask

  task automatic test_hazard;
    logic [31:0] h0, l0;
    bit got, chg; int n; logic [63:0] e;
    h0 = hi; l0 = lo;
    issue(2'd1, 32'h1234_5678, 32'hFFFF_FFF0, model(2'd1, 32'h1234_5678, 32'hFFFF_FFF0), 1);
    repeat (5) @(negedge clk);
    checks++;
    if (stall !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL busy_quiet stall=%b busy=%b expected 0 1", stall, busy); end
    for (int s = 0; s < 4; s++) begin
      hilo_rd = (s == 0); hi_we = (s == 1); lo_we = (s == 2); start = (s == 3);
      wdata = 32'hDEAD_BEEF; op = 2'd2; a = 32'd1; b = 32'd1;
      #1;
      checks++;
      if (stall !== 1'b1 || hi !== h0 || lo !== l0) begin
        failures++;
        $display("FAIL hazard_stall s=%0d stall=%b hi=%h lo=%h expected 1 %h %h", s, stall, hi, lo, h0, l0);
      end
      @(negedge clk);
    end
    hilo_rd = 1'b0; hi_we = 1'b0; lo_we = 1'b0; start = 1'b0;
    checks++;
    if (hi !== h0 || lo !== l0) begin failures++; $display("FAIL hazard_ignored hi=%h lo=%h expected %h %h", hi, lo, h0, l0); end
    wait_result(got, n, chg);
    e = exp_q.pop_front();
    checks++;
    if (!got || n !== 25 || chg) begin failures++; $display("FAIL hazard_timing got=%b busy_left=%0d changed=%b expected 1 25 0", got, n, chg); end
    checks++;
    if ({hi, lo} !== e) begin failures++; $display("FAIL hazard_result got=%h expected=%h", {hi, lo}, e); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL hazard_no_restart busy=%b done=%b expected 0 0", busy, done); end
  endtask

  task automatic test_back_to_back;
    bit got, chg; int n; logic [63:0] e;
    logic [1:0] rop; logic [31:0] ra, rb;
    rop = 2'($urandom_range(0, 3)); ra = $urandom; rb = $urandom;
    issue(rop, ra, rb, model(rop, ra, rb), 1);
    for (int k = 0; k < 6; k++) begin
      wait_result(got, n, chg);
      e = exp_q.pop_front();
      checks++;
      if (!got || (k > 0 && n !== 34)) begin failures++; $display("FAIL b2b_accept k=%0d got=%b busy=%0d expected 1 34", k, got, n); end
      checks++;
      if ({hi, lo} !== e) begin failures++; $display("FAIL b2b_result k=%0d got=%h expected=%h", k, {hi, lo}, e); end
      if (k < 5) begin
        rop = 2'($urandom_range(0, 3)); ra = $urandom;
        rb = (k == 2) ? 32'd0 : ((k == 3) ? 32'($urandom_range(1, 16)) : $urandom);
        issue(rop, ra, rb, model(rop, ra, rb), 1);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit got, chg; int n; logic [63:0] e;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAAAA_5555;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    issue(2'd2, 32'hFFFF_0000, 32'd3, 64'd0, 0);
    repeat (16) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid busy=%b hi=%h lo=%h done=%b expected 0 0 0 0", busy, hi, lo, done);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_mid_quiet cyc=%0d done=%b busy=%b expected 0 0", i, done, busy); break; end
    end
    issue(2'd2, 32'd9, 32'd4, 64'h0000_0001_0000_0002, 1);
    wait_result(got, n, chg);
    e = exp_q.pop_front();
    checks++;
    if (!got || {hi, lo} !== e) begin failures++; $display("FAIL reset_mid_divu got=%b val=%h expected=%h", got, {hi, lo}, e); end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    hilo_rd = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    test_reset();
    test_mul();
    test_div();
    test_mthi_mtlo();
    test_hazard();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left size=%0d expected=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
